seven_seg_scan_decoder: RTL and testbench
=========================================

Name: seven_seg_scan_decoder

Overview:
- Receive-side counterpart of the clock's multiplexed display driver.
- Samples the scanned seven-segment bus (seg, dp, per-digit enables) and filters out ghosting during digit transitions.
- Decodes each glyph back to BCD and assembles a complete frame of all digits.
- Used as an on-chip loopback checker and as a host-readable time source; it sits beside the clock core and observes its display outputs.

Parameters:
- NUM_DIGITS, 8, number of digit enables scanned (width of dispEn).
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (≥2).
- SEG_ACTIVE_LOW, 0, 1 = seg/dp are active-low on the bus; the block inverts internally.
- EN_ACTIVE_LOW, 0, 1 = dispEn is active-low on the bus; the block inverts internally.
- TIMEOUT, 65535, cycles without any capture before stale asserts.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  capture enable.
- clr_err  in  1  synchronous clear of the sticky error flag.
- seg  in  7  segment bus; bit0=a … bit6=g.
- dp  in  1  decimal point.
- dispEn  in  NUM_DIGITS  digit enables; bit i selects digit i.
- frame_bcd  out  4*NUM_DIGITS  last complete frame; digit i occupies bits [4i+3:4i].
- frame_dp  out  NUM_DIGITS  dp bit per digit of the last frame.
- frame_valid  out  1  one-cycle pulse when frame_bcd/frame_dp update.
- err  out  1  sticky: an illegal glyph was captured.
- stale  out  1  no capture for TIMEOUT cycles.

Behaviour:
- Reset values: frame_bcd all 0xF, frame_dp 0, frame_valid 0, err 0, stale 0. Internal state: shadow digits 0xF, seen mask 0, state IDLE, counters 0.
- Input path:
  - Two-flop synchronizer on seg, dp and dispEn.
  - Polarity normalised per parameters, so internally 1 means lit/enabled.
  - Then one sample register s_q. Comparison is between the synchronizer output and s_q.
- State machine:
  - IDLE: entered whenever the synced enable vector is not one-hot (zero or multiple bits) or en=0. Stability counter is held at 0.
  - SETTLE: entered when the vector is one-hot. If the current sample equals s_q, the counter increments. If any bit differs, the counter goes to 0 and the state stays SETTLE.
  - SETTLE → CAPTURED: when the samples are equal and the counter equals STABLE_CYCLES-1, the digit is written on that edge.
  - CAPTURED: hold until the sample differs, then go to SETTLE (or to IDLE per the rule above). A steady pattern is captured only once.
- Latency: a pattern stable on the pins from edge 0 is written to the shadow register at edge 3+STABLE_CYCLES.
- Glyph decode (after normalisation):
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Blank 0x00 decodes to 0xF (legal).
  - Any other pattern decodes to 0xE and sets err on the capture edge.
  - dp is stored per digit unchanged.
- Capture of digit i: shadow[i] ← code, seen[i] ← 1, stale counter cleared, stale ← 0.
- Frame publish:
  - On the capture edge where seen would become all ones, frame_bcd/frame_dp load the shadow merged with the new digit, and the seen mask clears to 0.
  - frame_valid is high for exactly the following cycle.
  - Recaptures of an already-seen digit overwrite the shadow and do not publish.
- err: sticky until reset or clr_err=1. If an illegal capture and clr_err occur on the same edge, err is set (set wins).
- stale: a counter increments each cycle with no capture, saturating at TIMEOUT. stale=1 while it equals TIMEOUT.
- en=0 mid-settle: abort to IDLE, no write. The seen mask and frames are retained, and the stale counter keeps running.
- Asynchronous reset mid-frame: all state returns to reset values immediately, and the partial frame is discarded.

Test Plan:
- Single digit: STABLE_CYCLES=4, enable bit 2 with seg=0x5B held 10 cycles → shadow[2]=0x2, written at edge 7, exactly one capture.
- Full scan: cycle digits 0..7 with glyphs for 1,2,3,4,5,6,7,8, each held 8 cycles → frame_bcd=0x87654321, one frame_valid pulse one cycle after the digit-7 capture, seen mask cleared.
- Ghosting: between digits, drive dispEn=0b00000011 for 2 cycles, then a 2-cycle glitchy seg → no capture, no err, state IDLE/SETTLE only.
- Illegal glyph: seg=0x49 on digit 0 held 8 cycles → code 0xE, err=1. Pulse clr_err → err=0. Illegal capture coincident with clr_err → err stays 1.
- Polarity: SEG_ACTIVE_LOW=1, EN_ACTIVE_LOW=1, full scan of inverted patterns → same frame_bcd as the scan test.
- Timeout/reset: TIMEOUT=20, no enables for 25 cycles → stale=1 from the cycle the counter reaches 20; next capture clears it. Assert rst_n low mid-scan → outputs return to reset values immediately, and no frame_valid after release until a full new scan completes.

Source files
------------

// File: rtl/seven_seg_scan_decoder_if.sv
// Scanned display bus plus decoded-frame outputs shared between the clock core side and the host side.
interface seven_seg_scan_decoder_if #(
  parameter int unsigned NUM_DIGITS = 8
);
  logic                      en;
  logic                      clr_err;
  logic [6:0]                seg;
  logic                      dp;
  logic [NUM_DIGITS-1:0]     dispEn;
  logic [4*NUM_DIGITS-1:0]   frame_bcd;
  logic [NUM_DIGITS-1:0]     frame_dp;
  logic                      frame_valid;
  logic                      err;
  logic                      stale;

  modport master (
    output en, clr_err, seg, dp, dispEn,
    input  frame_bcd, frame_dp, frame_valid, err, stale
  );

  modport slave (
    input  en, clr_err, seg, dp, dispEn,
    output frame_bcd, frame_dp, frame_valid, err, stale
  );
endinterface

// File: rtl/seven_seg_scan_decoder.sv
// Watches a multiplexed seven-segment bus, rejects transition ghosting and
// rebuilds a full BCD frame of all scanned digits.
module seven_seg_scan_decoder #(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          EN_ACTIVE_LOW  = 1'b0,
  parameter int unsigned TIMEOUT        = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seven_seg_scan_decoder_if.slave bus
);

  localparam int unsigned CNT_W   = $clog2(STABLE_CYCLES);
  localparam int unsigned STALE_W = $clog2(TIMEOUT + 1);
  localparam int unsigned BCD_W   = 4 * NUM_DIGITS;

  typedef struct packed {
    logic [6:0]            seg;
    logic                  dp;
    logic [NUM_DIGITS-1:0] en;
  } sample_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_CAPTURED = 2'd2
  } state_t;

  sample_t                r_sync1, r_sync2, r_sq;
  sample_t                w_norm;
  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [BCD_W-1:0]       r_shadow, w_shadow_nxt;
  logic [NUM_DIGITS-1:0]  r_shadow_dp, w_shadow_dp_nxt;
  logic [NUM_DIGITS-1:0]  r_seen, w_seen_nxt;
  logic [BCD_W-1:0]       r_frame_bcd;
  logic [NUM_DIGITS-1:0]  r_frame_dp;
  logic                   r_frame_valid;
  logic                   r_err;
  logic [STALE_W-1:0]     r_stale_cnt, w_stale_cnt_nxt;
  logic                   r_stale;
  logic                   w_equal, w_onehot, w_capture, w_publish, w_illegal;
  logic [3:0]             w_code;

  function automatic logic [3:0] f_decode(input logic [6:0] g);
    logic [3:0] code;
    case (g)
      7'h3F:   code = 4'h0;
      7'h06:   code = 4'h1;
      7'h5B:   code = 4'h2;
      7'h4F:   code = 4'h3;
      7'h66:   code = 4'h4;
      7'h6D:   code = 4'h5;
      7'h7D:   code = 4'h6;
      7'h07:   code = 4'h7;
      7'h7F:   code = 4'h8;
      7'h6F:   code = 4'h9;
      7'h00:   code = 4'hF;
      default: code = 4'hE;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer on the raw bus, then the normalised sample register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sq    <= '0;
    end else begin
      r_sync1 <= '{seg: bus.seg, dp: bus.dp, en: bus.dispEn};
      r_sync2 <= r_sync1;
      r_sq    <= w_norm;
    end
  end

  always_comb begin
    w_norm.seg = r_sync2.seg ^ {7{SEG_ACTIVE_LOW}};
    w_norm.dp  = r_sync2.dp ^ SEG_ACTIVE_LOW;
    w_norm.en  = r_sync2.en ^ {NUM_DIGITS{EN_ACTIVE_LOW}};
  end

  assign w_equal   = (w_norm == r_sq);
  assign w_onehot  = (r_sq.en != '0) && ((r_sq.en & (r_sq.en - NUM_DIGITS'(1))) == '0);
  assign w_code    = f_decode(r_sq.seg);
  assign w_illegal = (w_code == 4'hE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A digit is accepted only after STABLE_CYCLES identical one-hot samples
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    if (!bus.en || !w_onehot) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = '0;
        end
        ST_SETTLE: begin
          if (!w_equal) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_CAPTURED;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_CAPTURED: begin
          if (!w_equal) begin
            w_state_nxt = ST_SETTLE;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Shadow frame with the incoming digit merged in
  always_comb begin
    w_shadow_nxt    = r_shadow;
    w_shadow_dp_nxt = r_shadow_dp;
    w_seen_nxt      = r_seen | r_sq.en;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (r_sq.en[i]) begin
        w_shadow_nxt[4*i +: 4] = w_code;
        w_shadow_dp_nxt[i]     = r_sq.dp;
      end
    end
  end

  assign w_publish = w_capture && (&w_seen_nxt);

  always_comb begin
    if (w_capture)
      w_stale_cnt_nxt = '0;
    else if (r_stale_cnt == STALE_W'(TIMEOUT))
      w_stale_cnt_nxt = r_stale_cnt;
    else
      w_stale_cnt_nxt = r_stale_cnt + STALE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow      <= {NUM_DIGITS{4'hF}};
      r_shadow_dp   <= '0;
      r_seen        <= '0;
      r_frame_bcd   <= {NUM_DIGITS{4'hF}};
      r_frame_dp    <= '0;
      r_frame_valid <= 1'b0;
      r_err         <= 1'b0;
      r_stale_cnt   <= '0;
      r_stale       <= 1'b0;
    end else begin
      if (w_capture) begin
        r_shadow    <= w_shadow_nxt;
        r_shadow_dp <= w_shadow_dp_nxt;
        r_seen      <= w_publish ? '0 : w_seen_nxt;
      end
      if (w_publish) begin
        r_frame_bcd <= w_shadow_nxt;
        r_frame_dp  <= w_shadow_dp_nxt;
      end
      r_frame_valid <= w_publish;
      // Setting on an illegal capture outranks a simultaneous clear
      if (w_capture && w_illegal)
        r_err <= 1'b1;
      else if (bus.clr_err)
        r_err <= 1'b0;
      r_stale_cnt <= w_stale_cnt_nxt;
      r_stale     <= (w_stale_cnt_nxt == STALE_W'(TIMEOUT));
    end
  end

  assign bus.frame_bcd   = r_frame_bcd;
  assign bus.frame_dp    = r_frame_dp;
  assign bus.frame_valid = r_frame_valid;
  assign bus.err         = r_err;
  assign bus.stale       = r_stale;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Scoreboard bench: a normal-polarity and an inverted-polarity decoder watch the same scan.
module tb_seven_seg_scan_decoder;

  localparam int unsigned N = 8;

  typedef struct packed {
    logic [4*N-1:0] bcd;
    logic [N-1:0]   dp;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seven_seg_scan_decoder_if #(.NUM_DIGITS(N)) bus ();
  seven_seg_scan_decoder_if #(.NUM_DIGITS(N)) bus_n ();

  assign bus_n.en      = bus.en;
  assign bus_n.clr_err = bus.clr_err;
  assign bus_n.seg     = ~bus.seg;
  assign bus_n.dp      = ~bus.dp;
  assign bus_n.dispEn  = ~bus.dispEn;

  seven_seg_scan_decoder #(
    .NUM_DIGITS(N), .STABLE_CYCLES(4), .SEG_ACTIVE_LOW(1'b0), .EN_ACTIVE_LOW(1'b0), .TIMEOUT(20)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  seven_seg_scan_decoder #(
    .NUM_DIGITS(N), .STABLE_CYCLES(4), .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b1), .TIMEOUT(20)
  ) u_inv (.clk(clk), .rst_n(rst_n), .bus(bus_n));

  logic [6:0] glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  frame_t q_main[$];
  frame_t q_inv[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_frames = 0;
  int n_frames_inv = 0;
  int n_cap = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_frame(input logic [4*N-1:0] bcd, input logic [N-1:0] dp);
    frame_t f;
    f.bcd = bcd;
    f.dp  = dp;
    q_main.push_back(f);
    q_inv.push_back(f);
  endtask

  task automatic show(input logic [N-1:0] e, input logic [6:0] s, input logic p, input int cyc);
    @(negedge clk);
    bus.dispEn = e;
    bus.seg    = s;
    bus.dp     = p;
    repeat (cyc) @(posedge clk);
  endtask

  always @(posedge clk) if (dut.w_capture) n_cap++;

  // Monitors: every frame_valid pulse must match the oldest expected frame
  always @(negedge clk) begin
    if (bus.frame_valid) begin
      n_checks++;
      if (q_main.size() == 0) begin
        n_errors++;
        $display("FAIL main_unexpected_frame: got %h/%h expected no frame", bus.frame_bcd, bus.frame_dp);
      end else begin
        frame_t e;
        e = q_main.pop_front();
        if ({bus.frame_bcd, bus.frame_dp} !== e) begin
          n_errors++;
          $display("FAIL main_frame: got %h/%h expected %h/%h", bus.frame_bcd, bus.frame_dp, e.bcd, e.dp);
        end
      end
      n_frames++;
    end
  end

  always @(negedge clk) begin
    if (bus_n.frame_valid) begin
      n_checks++;
      if (q_inv.size() == 0) begin
        n_errors++;
        $display("FAIL inv_unexpected_frame: got %h/%h expected no frame", bus_n.frame_bcd, bus_n.frame_dp);
      end else begin
        frame_t e;
        e = q_inv.pop_front();
        if ({bus_n.frame_bcd, bus_n.frame_dp} !== e) begin
          n_errors++;
          $display("FAIL inv_frame: got %h/%h expected %h/%h", bus_n.frame_bcd, bus_n.frame_dp, e.bcd, e.dp);
        end
      end
      n_frames_inv++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst_n       = 1'b0;
    bus.en      = 1'b0;
    bus.clr_err = 1'b0;
    bus.seg     = '0;
    bus.dp      = 1'b0;
    bus.dispEn  = '0;
    #12;
    chk("rst_frame_bcd", 64'(bus.frame_bcd), 64'hFFFF_FFFF);
    chk("rst_frame_dp", 64'(bus.frame_dp), 64'h0);
    chk("rst_frame_valid", 64'(bus.frame_valid), 64'h0);
    chk("rst_err", 64'(bus.err), 64'h0);
    chk("rst_stale", 64'(bus.stale), 64'h0);
    chk("rst_inv_frame_bcd", 64'(bus_n.frame_bcd), 64'hFFFF_FFFF);
    @(negedge clk);
    rst_n  = 1'b1;
    bus.en = 1'b1;
    repeat (2) @(negedge clk);

    // Single digit latency: pins change before edge 0, write lands on edge 7
    n0 = n_cap;
    bus.dispEn = 8'h04;
    bus.seg    = 7'h5B;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("seen_before_edge7", 64'(dut.r_seen), 64'h00);
    @(negedge clk);
    chk("seen_after_edge7", 64'(dut.r_seen), 64'h04);
    chk("shadow_digit2", 64'(dut.r_shadow[11:8]), 64'h2);
    repeat (2) @(negedge clk);
    chk("single_capture_count", 64'(n_cap - n0), 64'd1);

    // Full scan of 1..8 with a ghosting burst before digit 4
    push_frame(32'h8765_4321, 8'h22);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        n0 = n_cap;
        show(8'h03, glyph[5], 1'b0, 2);
        show(8'h10, 7'h49, 1'b0, 1);
        show(8'h10, 7'h12, 1'b0, 1);
      end
      show(N'(1) << i, glyph[i+1], (i == 1 || i == 5), 8);
      if (i == 4) begin
        chk("ghost_single_capture", 64'(n_cap - n0), 64'd1);
        chk("ghost_no_err", 64'(bus.err), 64'h0);
      end
    end
    @(negedge clk);
    chk("scan_frames", 64'(n_frames), 64'd1);
    chk("scan_seen_cleared", 64'(dut.r_seen), 64'h00);
    chk("scan_inv_frames", 64'(n_frames_inv), 64'd1);

    // Illegal glyph, clear, then illegal capture coincident with clear
    show(8'h01, 7'h49, 1'b0, 8);
    @(negedge clk);
    chk("illegal_err_set", 64'(bus.err), 64'h1);
    chk("illegal_shadow_code", 64'(dut.r_shadow[3:0]), 64'hE);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    chk("clr_err_clears", 64'(bus.err), 64'h0);
    n0 = n_cap;
    bus.dispEn = 8'h02;
    bus.seg    = 7'h12;
    repeat (6) @(negedge clk);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    chk("coincident_capture", 64'(n_cap - n0), 64'd1);
    chk("coincident_err_wins", 64'(bus.err), 64'h1);

    // Stale: counter restarted by the capture just above
    bus.dispEn = '0;
    repeat (19) @(negedge clk);
    chk("stale_at_19", 64'(bus.stale), 64'h0);
    @(negedge clk);
    chk("stale_at_20", 64'(bus.stale), 64'h1);
    repeat (5) @(negedge clk);
    chk("stale_saturated", 64'(bus.stale), 64'h1);
    show(8'h04, glyph[0], 1'b0, 8);
    @(negedge clk);
    chk("stale_cleared_by_capture", 64'(bus.stale), 64'h0);

    // Asynchronous reset in the middle of a scan
    for (int i = 0; i < 4; i++) show(N'(1) << i, glyph[i], 1'b0, 8);
    show(8'h10, glyph[4], 1'b0, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_frame_bcd", 64'(bus.frame_bcd), 64'hFFFF_FFFF);
    chk("mid_rst_frame_dp", 64'(bus.frame_dp), 64'h0);
    chk("mid_rst_err", 64'(bus.err), 64'h0);
    chk("mid_rst_stale", 64'(bus.stale), 64'h0);
    chk("mid_rst_seen", 64'(dut.r_seen), 64'h00);
    @(negedge clk);
    rst_n = 1'b1;
    show(8'h10, glyph[9], 1'b0, 8);
    show(8'h20, glyph[0], 1'b0, 8);
    show(8'h40, 7'h00, 1'b0, 8);
    show(8'h80, glyph[5], 1'b1, 8);
    @(negedge clk);
    chk("no_frame_half_scan", 64'(n_frames), 64'd1);
    push_frame(32'h5F09_3876, 8'h80);
    show(8'h01, glyph[6], 1'b0, 8);
    show(8'h02, glyph[7], 1'b0, 8);
    show(8'h04, glyph[8], 1'b0, 8);
    show(8'h08, glyph[3], 1'b0, 8);
    repeat (3) @(negedge clk);
    chk("post_rst_frames", 64'(n_frames), 64'd2);
    chk("post_rst_inv_frames", 64'(n_frames_inv), 64'd2);
    chk("queues_drained", 64'(q_main.size() + q_inv.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
